// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; count, pointers and memory image are exported
// for an external assertion checker. Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          fifo_write,
  input  logic                          fifo_read,
  input  logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [DATA_WIDTH-1:0]         fifo_data_out,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [ADDR_WIDTH:0]           FIFO_COUNT,
  output logic [ADDR_WIDTH-1:0]         write_pointer,
  output logic [ADDR_WIDTH-1:0]         read_pointer,
  output logic [DEPTH*DATA_WIDTH-1:0]   fifo_data_mem
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                          fifo_overflow,
  output logic                          fifo_underflow
`endif
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  wr_acc, rd_acc;

  // Acceptance is judged on the registered flags, so a full FIFO never takes a write
  // even when a read frees a slot on the same edge (and likewise for empty/read).
  assign wr_acc = fifo_write && !full_q && !reset;
  assign rd_acc = fifo_read && !empty_q && !reset;

  always_comb begin
    dout_d   = dout_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      dout_d   = mem_q[rd_ptr_q];
    end
    if (wr_acc && !rd_acc) count_d = count_q + (ADDR_WIDTH + 1)'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - (ADDR_WIDTH + 1)'(1);
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dout_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      dout_q   <= dout_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is deliberately not reset; stale contents stay visible on fifo_data_mem.
  always_ff @(posedge clock) begin
    if (wr_acc) mem_q[wr_ptr_q] <= fifo_data_in;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem_flat
      assign fifo_data_mem[gi*DATA_WIDTH +: DATA_WIDTH] = mem_q[gi];
    end
  endgenerate

  assign fifo_data_out = dout_q;
  assign FIFO_COUNT    = count_q;
  assign write_pointer = wr_ptr_q;
  assign read_pointer  = rd_ptr_q;
  assign fifo_full     = full_q;
  assign fifo_empty    = empty_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  assign ovf_d = ovf_q || (fifo_write && full_q);
  assign udf_d = udf_q || (fifo_read && empty_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign fifo_overflow  = ovf_q;
  assign fifo_underflow = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus a randomized run against a queue model.
module tb_sync_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_write = 1'b0;
  logic        fifo_read = 1'b0;
  logic [7:0]  fifo_data_in = 8'h00;
  logic [7:0]  fifo_data_out;
  logic        fifo_full, fifo_empty;
  logic [3:0]  FIFO_COUNT;
  logic [2:0]  write_pointer, read_pointer;
  logic [63:0] fifo_data_mem;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic        fifo_overflow, fifo_underflow;
`endif

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clock(clock), .reset(reset), .fifo_write(fifo_write), .fifo_read(fifo_read),
    .fifo_data_in(fifo_data_in), .fifo_data_out(fifo_data_out),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .FIFO_COUNT(FIFO_COUNT),
    .write_pointer(write_pointer), .read_pointer(read_pointer), .fifo_data_mem(fifo_data_mem)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of entries plus counters of writes/reads taken modulo the depth.
  logic [7:0] q[$];
  logic [7:0] m_mem [8];
  bit         m_known [8];
  int         m_wp = 0, m_rp = 0;
  logic [7:0] m_dout = 8'h00;
  bit         m_ovf = 0, m_udf = 0;

  // Drive one clock of stimulus, then advance the model to the post-edge state.
  task automatic cycle(input logic rst, input logic w, input logic r, input logic [7:0] d);
    bit wa, ra, ov, un;
    reset = rst; fifo_write = w; fifo_read = r; fifo_data_in = d;
    wa = w && (q.size() < 8);
    ra = r && (q.size() > 0);
    ov = w && (q.size() == 8);
    un = r && (q.size() == 0);
    @(posedge clock); #1;
    if (rst) begin
      q.delete(); m_wp = 0; m_rp = 0; m_dout = 8'h00; m_ovf = 0; m_udf = 0;
    end else begin
      if (ov) m_ovf = 1;
      if (un) m_udf = 1;
      if (ra) begin m_dout = q.pop_front(); m_rp = (m_rp + 1) % 8; end
      if (wa) begin
        q.push_back(d); m_mem[m_wp] = d; m_known[m_wp] = 1; m_wp = (m_wp + 1) % 8;
      end
    end
    reset = 1'b0; fifo_write = 1'b0; fifo_read = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 8'h00);
    cycle(1, 0, 0, 8'h00);
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b exp 1", fifo_empty); end
    n_cmp++; if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b exp 0", fifo_full); end
    n_cmp++; if (FIFO_COUNT !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", FIFO_COUNT); end
    n_cmp++; if ({write_pointer, read_pointer} !== 6'd0) begin n_bad++; $display("FAIL reset_ptrs got wp=%0d rp=%0d exp 0 0", write_pointer, read_pointer); end
    n_cmp++; if (fifo_data_out !== 8'h00) begin n_bad++; $display("FAIL reset_dout got %h exp 00", fifo_data_out); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    n_cmp++; if ({fifo_overflow, fifo_underflow} !== 2'b00) begin n_bad++; $display("FAIL reset_errflags got %b%b exp 00", fifo_overflow, fifo_underflow); end
`endif
    $display("test_reset: done");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      d = 8'(8'h11 * (i + 1));
      cycle(0, 1, 0, d);
      n_cmp++; if (FIFO_COUNT !== 4'(i + 1)) begin n_bad++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, FIFO_COUNT, i + 1); end
      n_cmp++; if (fifo_full !== (i == 7)) begin n_bad++; $display("FAIL fill_full[%0d] got %b exp %b", i, fifo_full, i == 7); end
      n_cmp++; if (fifo_empty !== 1'b0) begin n_bad++; $display("FAIL fill_empty[%0d] got %b exp 0", i, fifo_empty); end
      $display("fill write %h count=%0d", d, FIFO_COUNT);
    end
    n_cmp++; if (write_pointer !== 3'd0) begin n_bad++; $display("FAIL fill_wp_wrap got %0d exp 0", write_pointer); end
    n_cmp++; if (fifo_data_mem[56 +: 8] !== 8'h88) begin n_bad++; $display("FAIL fill_mem7 got %h exp 88", fifo_data_mem[56 +: 8]); end
  endtask

  task automatic test_overflow();
    logic [63:0] snap;
    for (int i = 0; i < 8; i++) snap[i*8 +: 8] = 8'(8'h11 * (i + 1));
    cycle(0, 1, 0, 8'hFF);
    $display("overflow write ff count=%0d", FIFO_COUNT);
    n_cmp++; if (FIFO_COUNT !== 4'd8) begin n_bad++; $display("FAIL ovf_count got %0d exp 8", FIFO_COUNT); end
    n_cmp++; if (fifo_data_mem !== snap) begin n_bad++; $display("FAIL ovf_mem got %h exp %h", fifo_data_mem, snap); end
    n_cmp++; if (write_pointer !== 3'd0) begin n_bad++; $display("FAIL ovf_wp got %0d exp 0", write_pointer); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    n_cmp++; if (fifo_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b exp 1", fifo_overflow); end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 8'h00);
      $display("drain read %h count=%0d", fifo_data_out, FIFO_COUNT);
      n_cmp++; if (fifo_data_out !== 8'(8'h11 * (i + 1))) begin n_bad++; $display("FAIL drain_dout[%0d] got %h exp %h", i, fifo_data_out, 8'(8'h11 * (i + 1))); end
      n_cmp++; if (FIFO_COUNT !== 4'(7 - i)) begin n_bad++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, FIFO_COUNT, 7 - i); end
    end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty got %b exp 1", fifo_empty); end
    n_cmp++; if (read_pointer !== 3'd0) begin n_bad++; $display("FAIL drain_rp got %0d exp 0", read_pointer); end
    cycle(0, 0, 1, 8'h00);
    $display("underflow read dout=%h", fifo_data_out);
    n_cmp++; if (fifo_data_out !== 8'h88) begin n_bad++; $display("FAIL udf_hold got %h exp 88", fifo_data_out); end
    n_cmp++; if (read_pointer !== 3'd0) begin n_bad++; $display("FAIL udf_rp got %0d exp 0", read_pointer); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    n_cmp++; if (fifo_underflow !== 1'b1) begin n_bad++; $display("FAIL udf_flag got %b exp 1", fifo_underflow); end
`endif
  endtask

  task automatic test_back_to_back();
    int wp0, rp0;
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'($urandom));
    wp0 = m_wp; rp0 = m_rp;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 1, 8'($urandom));
      $display("b2b cycle %0d dout=%h count=%0d", i, fifo_data_out, FIFO_COUNT);
      n_cmp++; if (FIFO_COUNT !== 4'd3) begin n_bad++; $display("FAIL b2b_count[%0d] got %0d exp 3", i, FIFO_COUNT); end
      n_cmp++; if (fifo_data_out !== m_dout) begin n_bad++; $display("FAIL b2b_dout[%0d] got %h exp %h", i, fifo_data_out, m_dout); end
    end
    n_cmp++; if (write_pointer !== 3'((wp0 + 10) % 8)) begin n_bad++; $display("FAIL b2b_wp got %0d exp %0d", write_pointer, (wp0 + 10) % 8); end
    n_cmp++; if (read_pointer !== 3'((rp0 + 10) % 8)) begin n_bad++; $display("FAIL b2b_rp got %0d exp %0d", read_pointer, (rp0 + 10) % 8); end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'($urandom));
    n_cmp++; if (FIFO_COUNT !== 4'd5) begin n_bad++; $display("FAIL rstmid_pre_count got %0d exp 5", FIFO_COUNT); end
    cycle(1, 1, 1, 8'hA5);
    $display("reset mid-stream count=%0d empty=%b", FIFO_COUNT, fifo_empty);
    n_cmp++; if (FIFO_COUNT !== 4'd0) begin n_bad++; $display("FAIL rstmid_count got %0d exp 0", FIFO_COUNT); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL rstmid_empty got %b exp 1", fifo_empty); end
    n_cmp++; if ({write_pointer, read_pointer} !== 6'd0) begin n_bad++; $display("FAIL rstmid_ptrs got wp=%0d rp=%0d exp 0 0", write_pointer, read_pointer); end
    n_cmp++; if (fifo_data_out !== 8'h00) begin n_bad++; $display("FAIL rstmid_dout got %h exp 00", fifo_data_out); end
    // First cycle after reset release must accept a write.
    cycle(0, 1, 0, 8'h5A);
    n_cmp++; if (FIFO_COUNT !== 4'd1) begin n_bad++; $display("FAIL post_rst_write got %0d exp 1", FIFO_COUNT); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic rst, w, r;
      logic [7:0] d;
      rst = ($urandom_range(0, 99) < 2);
      w   = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
      r   = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
      d   = 8'($urandom);
      cycle(rst, w, r, d);
      $display("rand %0d rst=%b w=%b r=%b d=%h -> dout=%h count=%0d", i, rst, w, r, d, fifo_data_out, FIFO_COUNT);
      n_cmp++;
      if ({fifo_data_out, FIFO_COUNT, fifo_full, fifo_empty, write_pointer, read_pointer} !==
          {m_dout, 4'(q.size()), q.size() == 8, q.size() == 0, 3'(m_wp), 3'(m_rp)}) begin
        n_bad++;
        $display("FAIL rand_state[%0d] got dout=%h cnt=%0d f=%b e=%b wp=%0d rp=%0d exp dout=%h cnt=%0d f=%b e=%b wp=%0d rp=%0d",
                 i, fifo_data_out, FIFO_COUNT, fifo_full, fifo_empty, write_pointer, read_pointer,
                 m_dout, q.size(), q.size() == 8, q.size() == 0, m_wp, m_rp);
      end
      for (int k = 0; k < 8; k++) begin
        if (m_known[k]) begin
          n_cmp++;
          if (fifo_data_mem[k*8 +: 8] !== m_mem[k]) begin n_bad++; $display("FAIL rand_mem[%0d][%0d] got %h exp %h", i, k, fifo_data_mem[k*8 +: 8], m_mem[k]); end
        end
      end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      n_cmp++;
      if ({fifo_overflow, fifo_underflow} !== {m_ovf, m_udf}) begin n_bad++; $display("FAIL rand_errflags[%0d] got %b%b exp %b%b", i, fifo_overflow, fifo_underflow, m_ovf, m_udf); end
`endif
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin m_mem[k] = 8'h00; m_known[k] = 0; end
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Synchronous single-clock FIFO, 8 entries of 8 bits by default, with registered read data, occupancy count, full/empty flags, and visible write/read pointers. It is the storage block that the team's FIFO assertion checker binds to. Every internal state that checker samples (count, pointers, memory image) is brought out as a port. It sits between a producer that issues `fifo_write` and a consumer that issues `fifo_read`, both in the same clock domain.

## Interface

**Parameters**
- `DATA_WIDTH`, default 8: width of one entry.
- `DEPTH`, default 8: number of entries; must be a power of two ≥ 2.
- `ADDR_WIDTH`, default 3: log2(DEPTH); pointer width.

**Ports** (one clock; reset is synchronous and active-high)
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `fifo_write`  in  1  write request.
- `fifo_read`  in  1  read request.
- `fifo_data_in`  in  DATA_WIDTH  write data.
- `fifo_data_out`  out  DATA_WIDTH  registered read data.
- `fifo_full`  out  1  count == DEPTH.
- `fifo_empty`  out  1  count == 0.
- `FIFO_COUNT`  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- `write_pointer`  out  ADDR_WIDTH  next write slot.
- `read_pointer`  out  ADDR_WIDTH  next read slot.
- `fifo_data_mem`  out  DEPTH*DATA_WIDTH  flattened memory image; entry i is at bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation

**Request acceptance**
- A write is accepted iff `fifo_write && !fifo_full`.
- A read is accepted iff `fifo_read && !fifo_empty`.
- Requests that are not accepted are dropped. They cause no state change.

**Accepted write**
- `mem[write_pointer] <= fifo_data_in`.
- `write_pointer` increments modulo DEPTH.

**Accepted read**
- `fifo_data_out <= mem[read_pointer]`.
- `read_pointer` increments modulo DEPTH.
- When no read is accepted, `fifo_data_out` holds its value.

**Count update**
- Write only: +1.
- Read only: −1.
- Both or neither: unchanged.

**Simultaneous requests**
- When full, a write is rejected even if a read is accepted in the same cycle.
- When empty, a read is rejected even if a write is accepted in the same cycle. No bypass path exists.
- When neither full nor empty, both requests are accepted. Both pointers advance and the count holds.

**Flags**
- `fifo_full` and `fifo_empty` are registers, updated on the same edge as `FIFO_COUNT`.
- At all times `fifo_full == (FIFO_COUNT == DEPTH)` and `fifo_empty == (FIFO_COUNT == 0)`.

**Pointers**
- Pointers wrap naturally at ADDR_WIDTH bits.
- Full versus empty is resolved by the count, never by pointer comparison.

**Reset values**
- `fifo_data_out` = 0, `FIFO_COUNT` = 0, `write_pointer` = 0, `read_pointer` = 0.
- `fifo_full` = 0, `fifo_empty` = 1.
- Memory contents are not reset. `fifo_data_mem` shows prior contents.

**Reset priority**
- Reset has priority over all requests.
- Asserting reset mid-stream discards all stored entries logically: count = 0, pointers = 0.

## Timing

- Write asserted before edge N is accepted at edge N. Directly after edge N:
  - `FIFO_COUNT`, `write_pointer`, `fifo_empty`/`fifo_full` and `fifo_data_mem` reflect the write.
- Read-data latency is 1 clock. A read accepted at edge N presents data on `fifo_data_out` directly after edge N, and it is stable until the next accepted read or reset.
- Minimum write-to-read turnaround: a write at edge N can be read at edge N+1, with data visible after edge N+1.
- Full throughput is one write and one read per clock in steady state.
- The first cycle after reset deassertion accepts requests normally.

## Configuration

Macro: `SYNC_FIFO_ERR_FLAGS_EN`.

**Defined**
- Two extra outputs: `fifo_overflow` (1 bit) and `fifo_underflow` (1 bit).
- Both are sticky. They reset to 0 and are cleared only by `reset`.
- `fifo_overflow` is set on the edge after `fifo_write && fifo_full`.
- `fifo_underflow` is set on the edge after `fifo_read && fifo_empty`.
- Dropped-request behaviour is otherwise unchanged.

**Undefined**
- The ports do not exist.
- Rejected requests are silently dropped.

## Test plan

1. Reset for 2 cycles, then release → `fifo_empty`=1, `fifo_full`=0, `FIFO_COUNT`=0, both pointers 0, `fifo_data_out`=0x00.
2. Write 0x11..0x88 on 8 consecutive cycles → `FIFO_COUNT` steps 1..8; `fifo_full`=1 after the 8th edge; `write_pointer` wraps to 0; `fifo_data_mem` entry 7 = 0x88.
3. From full, write 0xFF → count stays 8, memory unchanged. With the macro defined, `fifo_overflow`=1 after that edge.
4. From full, read 8 times → `fifo_data_out` = 0x11..0x88, one cycle after each read; `fifo_empty`=1 after the last; `read_pointer`=0. Read once more → `fifo_data_out` holds 0x88; with the macro, `fifo_underflow`=1.
5. Hold count at 3, then assert read and write together for 10 cycles → count stays 3, both pointers advance by 10 mod 8 = 2, output data stays in FIFO order.
6. Write 5 entries, then assert reset for one cycle with `fifo_write` and `fifo_read` high → after the edge, count=0, `fifo_empty`=1, pointers 0, `fifo_data_out`=0x00.
